i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (responder) that is the far end of the heart-rate sensor master.
- On the board test rig it emulates the sensor: the master addresses it, writes a register pointer, and reads back data, for example the heart-rate byte.
- Register storage stays outside this block. It exposes a read port and a write strobe, so the core or a testbench can provide the register contents.
- Oversamples SCL/SDA on the system clock; never stretches SCL.

Parameters:
- ADDR, 7'h0A, 7-bit target address matched after START.
- REG_AW, 8, width of register pointer (byte-wide).

Ports:
- clk  input  1  system clock; must be ≥ 8× SCL frequency.
- reset  input  1  asynchronous, active-high; returns block to IDLE.
- scl  input  1  I2C clock from master.
- sda  inout  1  I2C data; block only drives 0 or Z (open-drain).
- rd_addr  output  8  current register pointer, presented for read.
- rd_data  input  8  register contents at rd_addr; sampled when a read byte is loaded.
- wr_en  output  1  one-cycle pulse when a write data byte is complete.
- wr_addr  output  8  register address for wr_en.
- wr_data  output  8  data byte for wr_en.
- busy  output  1  high from an address match until STOP, or until a START not addressed to this target.

Behaviour:
- Reset values:
  - sda released (Z)
  - rd_addr = 0, wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0
  - state = IDLE, bit counter = 0, shift register = 0
- Input path:
  - scl and sda each pass through a 2-FF synchronizer.
  - Edge detect on the synchronized values; events act 3 clk after the pin change.
- Bus events:
  - START: synced sda falls while synced scl is high. Accepted in any state, so a repeated START is handled. Goes to ADDR with bit count 0.
  - STOP: synced sda rises while synced scl is high. From any state: go to IDLE, release sda, busy = 0.
- Bit timing:
  - Received bits are sampled on the scl rising edge, MSB first.
  - The target changes sda only on the scl falling edge.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits (7 address bits + R/W). On the falling edge after bit 8:
    - address = ADDR: drive sda low (ACK), busy = 1, go to ADDR_ACK.
    - otherwise: release sda, go to IDLE. No ACK, busy stays 0.
  - ADDR_ACK: on the next scl fall, release the ACK.
    - R/W = 0 and this is the first byte since START: go to PTR.
    - R/W = 0 otherwise: go to WDATA.
    - R/W = 1: load shift register from rd_data, drive its MSB (0 → drive low, 1 → Z), go to RDATA.
  - PTR: shift 8 bits into rd_addr. ACK on the following fall, then go to WDATA.
  - WDATA: shift 8 bits. On bit 8 complete:
    - wr_addr = rd_addr, wr_data = byte, wr_en pulses for 1 clk.
    - rd_addr increments, wrapping 8'hFF → 8'h00.
    - ACK, then stay in WDATA.
  - RDATA: shift out 8 bits on successive falls. After bit 8, release sda, go to RACK.
  - RACK: sample the master's ACK on the scl rise.
    - Increment rd_addr (wrap).
    - ACK (0): at the next fall, load rd_data at the new pointer, drive MSB, go to RDATA.
    - NACK (1): go to IDLE-wait. sda stays released; busy stays 1 until STOP or START.
- rd_addr is kept across transactions. A read without a new pointer write starts at the last pointer.
- Simultaneous events:
  - STOP/START detection takes priority over a data edge in the same clk.
  - wr_en and START in the same clk: the write still completes.
- Reset mid-transfer: sda released immediately (asynchronous); the transfer is lost and no wr_en is issued.
- A STOP arriving mid-byte aborts that byte; no wr_en is issued.

Test Plan:
- Write 0x14 (addr 0x0A, W), pointer 0x03, data 0x5A, STOP → target ACKs all 3 bytes; wr_en pulses once with wr_addr = 0x03, wr_data = 0x5A; rd_addr ends at 0x04; busy falls at STOP.
- Write pointer 0x00, repeated START, 0x15 (R), master ACKs 1 byte then NACKs, with rd_data model returning 0x48 at addr 0 and 0x49 at addr 1 → sda carries 0x48 then 0x49; rd_addr ends at 0x02; sda released after the NACK.
- Address 0x0B (W) → no ACK (sda stays Z on the 9th clock), busy stays 0, no wr_en.
- Pointer 0xFF followed by 2 data bytes 0x11, 0x22 → two wr_en pulses at addresses 0xFF and 0x00; rd_addr = 0x01 (wrap).
- STOP after 4 bits of a data byte → no wr_en, state returns to IDLE, busy = 0; a following valid transaction works normally.
- Assert reset while the target is driving ACK low → sda goes Z in the same cycle, all outputs return to reset values; the next START is accepted.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C responder emulating the heart-rate sensor on the board test rig.
// SCL/SDA are oversampled on clk.
// The core never stretches SCL.
// Register storage is external.
// The core presents a read pointer (rd_addr/rd_data) and a one-cycle write strobe (wr_en/wr_addr/wr_data).
// SDA is open-drain: the core only ever pulls it low or releases it.

module i2c_target #(
  parameter logic [6:0] ADDR   = 7'h0A,
  parameter int         REG_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  inout  wire               sda,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  // Protocol states
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RACK      = 4'd8;
  localparam logic [3:0] ST_WAIT      = 4'd9;

  // Input synchronizers plus one history stage for edge detection
  logic scl_meta_r, scl_sync_r, scl_prev_r;
  logic sda_meta_r, sda_sync_r, sda_prev_r;

  // Protocol state
  logic [3:0] state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic       rw_r;
  logic       mack_r;
  logic       sda_oe_r;
  logic       busy_r;

  // Decoded bus events
  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;
  logic [7:0] rx_byte_s;
  logic       byte_done_s;
  logic       ptr_done_s;
  logic       wdata_done_s;
  logic       rack_rise_s;

  // Open-drain pad: pull low or release, never drive high
  assign sda = sda_oe_r ? 1'b0 : 1'bz;

  assign busy = busy_r;

  // Edge and bus-condition decode on the synchronized pins
  assign scl_rise_s   = scl_sync_r & ~scl_prev_r;
  assign scl_fall_s   = ~scl_sync_r & scl_prev_r;
  assign start_s      = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
  assign stop_s       = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;

  // A byte completes on the 8th rising edge; this is the byte including that bit
  assign rx_byte_s    = {shift_r[6:0], sda_sync_r};
  assign byte_done_s  = scl_rise_s & (bit_cnt_r == 4'd7);
  assign ptr_done_s   = byte_done_s & (state_r == ST_PTR);
  assign wdata_done_s = byte_done_s & (state_r == ST_WDATA);
  assign rack_rise_s  = scl_rise_s & (state_r == ST_RACK) & (bit_cnt_r == 4'd0);

  // Two-flop synchronizers; the pins idle high, so the flops reset high to avoid phantom edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_meta_r <= scl;
      scl_sync_r <= scl_meta_r;
      scl_prev_r <= scl_sync_r;
      sda_meta_r <= sda;
      sda_sync_r <= sda_meta_r;
      sda_prev_r <= sda_sync_r;
    end
  end

  // Protocol FSM: START/STOP win over data edges; SDA only changes on SCL falls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'd0;
      rw_r      <= 1'b0;
      mack_r    <= 1'b1;
      sda_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else if (stop_s) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd0;
      sda_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else if (start_s) begin
      // busy is kept through a repeated START; an address mismatch clears it
      state_r   <= ST_ADDR;
      bit_cnt_r <= 4'd0;
      sda_oe_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= 4'd0;
        end

        ST_ADDR: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            shift_r   <= rx_byte_s;
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            if (shift_r[7:1] == ADDR) begin
              rw_r     <= shift_r[0];
              sda_oe_r <= 1'b1;
              busy_r   <= 1'b1;
              state_r  <= ST_ADDR_ACK;
            end else begin
              sda_oe_r <= 1'b0;
              busy_r   <= 1'b0;
              state_r  <= ST_IDLE;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_r <= 4'd0;
            if (rw_r) begin
              // Read: first data bit goes out on the same fall that ends the ACK
              shift_r  <= rd_data;
              sda_oe_r <= ~rd_data[7];
              state_r  <= ST_RDATA;
            end else begin
              // First byte after an addressed write is always the register pointer
              sda_oe_r <= 1'b0;
              state_r  <= ST_PTR;
            end
          end
        end

        ST_PTR, ST_WDATA: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            shift_r   <= rx_byte_s;
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            sda_oe_r <= 1'b1;
            state_r  <= (state_r == ST_PTR) ? ST_PTR_ACK : ST_WDATA_ACK;
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s) begin
            sda_oe_r  <= 1'b0;
            bit_cnt_r <= 4'd0;
            state_r   <= ST_WDATA;
          end
        end

        ST_RDATA: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            // Release for the master's ACK slot
            sda_oe_r  <= 1'b0;
            bit_cnt_r <= 4'd0;
            state_r   <= ST_RACK;
          end else if (scl_fall_s && (bit_cnt_r != 4'd0)) begin
            shift_r  <= {shift_r[6:0], 1'b0};
            sda_oe_r <= ~shift_r[6];
          end
        end

        ST_RACK: begin
          if (rack_rise_s) begin
            mack_r    <= sda_sync_r;
            bit_cnt_r <= 4'd1;
          end else if (scl_fall_s && (bit_cnt_r == 4'd1)) begin
            bit_cnt_r <= 4'd0;
            if (!mack_r) begin
              // Pointer already advanced on the ACK rise; rd_data reflects the next register
              shift_r  <= rd_data;
              sda_oe_r <= ~rd_data[7];
              state_r  <= ST_RDATA;
            end else begin
              sda_oe_r <= 1'b0;
              state_r  <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          sda_oe_r <= 1'b0;
        end

        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= 4'd0;
          sda_oe_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Register pointer: loaded by the pointer byte, advanced per written byte and per read ACK slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
    end else if (ptr_done_s) begin
      rd_addr <= REG_AW'(rx_byte_s);
    end else if (wdata_done_s || rack_rise_s) begin
      rd_addr <= rd_addr + REG_AW'(1);
    end
  end

  // Write strobe: one clk per completed data byte, independent of any coincident bus condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'd0;
    end else begin
      wr_en <= wdata_done_s;
      if (wdata_done_s) begin
        wr_addr <= rd_addr;
        wr_data <= rx_byte_s;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: the bench acts as I2C master and register model.
// Writes and reads are scoreboarded through queues.
module tb_i2c_target;

  localparam int Q = 5;   // quarter SCL period in clk cycles (SCL = clk/20)

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m_oe;
  tri1        sda;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  logic [7:0]  mem [256];
  logic [15:0] wq [$];
  logic [7:0]  rq [$];
  logic [15:0] wexp;

  int tests = 0;
  int fails = 0;

  assign sda     = sda_m_oe ? 1'b0 : 1'bz;
  assign rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  i2c_target #(.ADDR(7'h0A), .REG_AW(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .scl     (scl_m),
    .sda     (sda),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every wr_en cycle must match the oldest expected write
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      chk("wr_expected", (wq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (wq.size() > 0) begin
        wexp = wq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(wexp[15:8]));
        chk("wr_data", 32'(wr_data), 32'(wexp[7:0]));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    sda_m_oe = 1'b0; wait_clk(Q);
    scl_m    = 1'b1; wait_clk(Q);
    sda_m_oe = 1'b1; wait_clk(Q);
    scl_m    = 1'b0; wait_clk(Q);
  endtask

  task automatic stop_cond();
    sda_m_oe = 1'b1; wait_clk(Q);
    scl_m    = 1'b1; wait_clk(Q);
    sda_m_oe = 1'b0; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m_oe = ~b; wait_clk(Q);
    scl_m    = 1'b1; wait_clk(2*Q);
    scl_m    = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m_oe = 1'b0; wait_clk(Q);
    scl_m    = 1'b1; wait_clk(Q);
    ack      = sda;  wait_clk(Q);
    scl_m    = 1'b0; wait_clk(Q);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    b = 8'h00;
    sda_m_oe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      b = {b[6:0], sda}; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
    end
    send_bit(mack);
    sda_m_oe = 1'b0;
  endtask

  task automatic wr_acked(input string tag, input logic [7:0] b);
    logic ack;
    write_byte(b, ack);
    chk(tag, 32'(ack), 32'd0);
  endtask

  task automatic rd_check(input string tag, input logic mack);
    logic [7:0] got;
    logic [7:0] exp;
    read_byte(mack, got);
    exp = rq.pop_front();
    chk(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    logic ack;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[0] = 8'h48;
    mem[1] = 8'h49;
    scl_m = 1'b1; sda_m_oe = 1'b0; reset = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(5);

    // Reset state
    chk("rst_sda",     32'(sda),     32'd1);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);

    // Pointer 0x03, data 0x5A
    start_cond();
    wr_acked("t1_addr_ack", 8'h14);
    chk("t1_busy", 32'(busy), 32'd1);
    wr_acked("t1_ptr_ack", 8'h03);
    wq.push_back(16'h035A);
    wr_acked("t1_data_ack", 8'h5A);
    stop_cond();
    chk("t1_rd_addr", 32'(rd_addr), 32'h04);
    chk("t1_busy_stop", 32'(busy), 32'd0);

    // Pointer 0x00, repeated START, read two bytes (ACK then NACK)
    start_cond();
    wr_acked("t2_addr_ack", 8'h14);
    wr_acked("t2_ptr_ack", 8'h00);
    start_cond();
    wr_acked("t2_raddr_ack", 8'h15);
    rq.push_back(mem[0]);
    rd_check("t2_rd0", 1'b0);
    rq.push_back(mem[1]);
    rd_check("t2_rd1", 1'b1);
    wait_clk(Q);
    chk("t2_sda_released", 32'(sda), 32'd1);
    chk("t2_rd_addr", 32'(rd_addr), 32'h02);
    chk("t2_busy_wait", 32'(busy), 32'd1);
    stop_cond();
    chk("t2_busy_stop", 32'(busy), 32'd0);

    // Foreign address 0x0B: no ACK, never busy
    start_cond();
    write_byte(8'h16, ack);
    chk("t3_nack", 32'(ack), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    stop_cond();

    // Pointer wrap 0xFF -> 0x00
    start_cond();
    wr_acked("t4_addr_ack", 8'h14);
    wr_acked("t4_ptr_ack", 8'hFF);
    wq.push_back(16'hFF11);
    wr_acked("t4_d0_ack", 8'h11);
    wq.push_back(16'h0022);
    wr_acked("t4_d1_ack", 8'h22);
    stop_cond();
    chk("t4_rd_addr", 32'(rd_addr), 32'h01);

    // STOP after 4 bits of a data byte aborts it
    start_cond();
    wr_acked("t5_addr_ack", 8'h14);
    wr_acked("t5_ptr_ack", 8'h20);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    stop_cond();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rd_addr", 32'(rd_addr), 32'h20);
    start_cond();
    wr_acked("t5b_addr_ack", 8'h14);
    wr_acked("t5b_ptr_ack", 8'h30);
    wq.push_back(16'h3077);
    wr_acked("t5b_data_ack", 8'h77);
    stop_cond();
    chk("t5b_rd_addr", 32'(rd_addr), 32'h31);

    // Reset while ACK is being driven
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h14 >> i));
    sda_m_oe = 1'b0;
    wait_clk(Q);
    chk("t6_ack_driven", 32'(sda), 32'd0);
    reset = 1'b1;
    #1;
    chk("t6_sda_z",   32'(sda),     32'd1);
    chk("t6_busy",    32'(busy),    32'd0);
    chk("t6_rd_addr", 32'(rd_addr), 32'd0);
    chk("t6_wr_en",   32'(wr_en),   32'd0);
    chk("t6_wr_addr", 32'(wr_addr), 32'd0);
    chk("t6_wr_data", 32'(wr_data), 32'd0);
    wait_clk(2);
    scl_m = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(4);
    start_cond();
    wr_acked("t6b_addr_ack", 8'h14);
    wr_acked("t6b_ptr_ack", 8'h05);
    wq.push_back(16'h0599);
    wr_acked("t6b_data_ack", 8'h99);
    stop_cond();
    chk("t6b_rd_addr", 32'(rd_addr), 32'h06);
    chk("t6b_busy", 32'(busy), 32'd0);

    wait_clk(4);
    chk("wr_outstanding", 32'(wq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
